prog_sequencer: RTL

PROG_SEQUENCER -- requirements
Module: prog_sequencer

---
 rtl/prog_sequencer.sv | 113 +++++++++++
 1 files changed

// File: rtl/prog_sequencer.sv
// prog_sequencer: IDLE/RUN/DONE program sequencer with PC, decoder mode, compare flags and run-cycle watchdog.
// Latency: req at edge N -> active=1, prog_ctr=0 after N; decode_ack (or limit) at edge M -> ack=1 after M.
// Backpressure: none; req is sampled only in IDLE/DONE, ignored while running.
// Ports: clk/rst_n (async active-low); req start; instruction word at prog_ctr; next_state/branch_en/
//   branch_target/decode_ack from the decoder; cmp_load_en/cmp_bits_in flag update; outputs prog_ctr,
//   curr_state, prev_instruction, cmp_bits, active (RUN), ack (DONE), timeout (DONE via cycle limit).
module prog_sequencer #(
  parameter int          PC_W    = 10,
  parameter logic [15:0] TIMEOUT = 16'd4000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req,
  input  logic [8:0]      instruction,
  input  logic [1:0]      next_state,
  input  logic            branch_en,
  input  logic [8:0]      branch_target,
  input  logic            decode_ack,
  input  logic            cmp_load_en,
  input  logic [2:0]      cmp_bits_in,
  output logic [PC_W-1:0] prog_ctr,
  output logic [1:0]      curr_state,
  output logic [8:0]      prev_instruction,
  output logic [2:0]      cmp_bits,
  output logic            active,
  output logic            ack,
  output logic            timeout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [15:0] cyc_cnt;
  logic [1:0]  mode_q;
  logic        timed_out_q;

  logic run;
  logic start;
  logic limit_hit;

  assign run   = (state_q == S_RUN);
  assign start = !run && req;
  // decode_ack wins over the watchdog when both land on the same cycle
  assign limit_hit = run && !decode_ack && (cyc_cnt == TIMEOUT - 16'd1);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req) state_d = S_RUN;
      S_RUN:   if (decode_ack || limit_hit) state_d = S_DONE;
      S_DONE:  if (req) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // outputs; the decoder mode only means something while running
  always_comb begin
    active     = run;
    ack        = (state_q == S_DONE);
    timeout    = (state_q == S_DONE) && timed_out_q;
    curr_state = run ? mode_q : 2'b00;
  end

  // datapath: PC, mode, previous word, flags, cycle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prog_ctr         <= '0;
      mode_q           <= 2'b00;
      prev_instruction <= 9'd0;
      cmp_bits         <= 3'b000;
      cyc_cnt          <= 16'd0;
      timed_out_q      <= 1'b0;
    end else if (start) begin
      prog_ctr         <= '0;
      mode_q           <= 2'b00;
      prev_instruction <= 9'd0;
      cmp_bits         <= 3'b000;
      cyc_cnt          <= 16'd0;
      timed_out_q      <= 1'b0;
    end else if (run) begin
      cyc_cnt <= cyc_cnt + 16'd1;
      if (cmp_load_en) begin
        cmp_bits <= cmp_bits_in;
      end
      // end-of-program freezes PC/mode/prev even if a branch is also flagged
      if (!decode_ack) begin
        prev_instruction <= instruction;
        mode_q           <= (next_state == 2'b11) ? 2'b00 : next_state;
        // size cast zero-extends or truncates the 9-bit target to PC_W
        prog_ctr         <= branch_en ? PC_W'(branch_target) : prog_ctr + PC_W'(1);
      end
      if (limit_hit) begin
        timed_out_q <= 1'b1;
      end
    end
  end

endmodule
